// File: rtl/fft_stage_pair_buffer.sv
// Ping-pong reorder buffer: collects an N-sample frame serially and replays it
// as radix-2 DIT butterfly operand pairs with twiddle indices for one stage.
module fft_stage_pair_buffer #(
  parameter int unsigned LOG2N     = 5,
  parameter int unsigned STAGE     = 0,
  parameter bit          BITREV_IN = 1'b1
) (
  input  logic               clock_c,
  input  logic               reset,
  input  logic [15:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               out_en,
  output logic [15:0]        out_a,
  output logic [15:0]        out_b,
  output logic [LOG2N-2:0]   out_tw,
  output logic               out_valid,
  output logic               out_last
);

  localparam int unsigned N        = 1 << LOG2N;
  localparam int unsigned NP       = N / 2;
  localparam int unsigned TWW      = LOG2N - 1;
  localparam int unsigned H        = 1 << STAGE;
  localparam int unsigned TW_SHIFT = LOG2N - 1 - STAGE;

  typedef enum logic [1:0] {
    B_EMPTY    = 2'd0,
    B_FILLING  = 2'd1,
    B_FULL     = 2'd2,
    B_DRAINING = 2'd3
  } bank_state_e;

  // Both banks share one array; the MSB of the address selects the bank.
  logic [15:0]        bank_mem [2*N];

  bank_state_e        bank_st_q [2];
  bank_state_e        bank_st_d [2];
  logic               wb_q, wb_d;
  logic               rb_q, rb_d;
  logic [LOG2N-1:0]   wcnt_q, wcnt_d;
  logic [TWW-1:0]     m_q, m_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [15:0]        out_a_q, out_a_d;
  logic [15:0]        out_b_q, out_b_d;
  logic [TWW-1:0]     out_tw_q, out_tw_d;

  logic               wr_fire;
  logic               rd_fire;
  logic [LOG2N-1:0]   wr_addr;
  logic [LOG2N-1:0]   m_ext;
  logic [LOG2N-1:0]   j_idx;
  logic [LOG2N-1:0]   top_idx;
  logic [LOG2N-1:0]   bot_idx;
  logic [TWW-1:0]     tw_idx;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    return {<<{v}};
  endfunction

  // Write address and butterfly pair addressing for the current pair index.
  always_comb begin
    wr_addr = BITREV_IN ? bitrev(wcnt_q) : wcnt_q;
    m_ext   = LOG2N'(m_q);
    j_idx   = m_ext & LOG2N'(H - 1);
    top_idx = ((m_ext >> STAGE) << (STAGE + 1)) | j_idx;
    bot_idx = top_idx | LOG2N'(H);
    tw_idx  = TWW'(j_idx) << TW_SHIFT;
  end

  // Bank state machines, counters and registered output values.
  always_comb begin
    bank_st_d   = bank_st_q;
    wb_d        = wb_q;
    rb_d        = rb_q;
    wcnt_d      = wcnt_q;
    m_d         = m_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_tw_d    = out_tw_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;

    wr_fire = in_valid && in_ready_q;
    rd_fire = out_en && ((bank_st_q[rb_q] == B_FULL) || (bank_st_q[rb_q] == B_DRAINING));

    if (wr_fire) begin
      if (wcnt_q == LOG2N'(N - 1)) begin
        bank_st_d[wb_q] = B_FULL;
        wcnt_d          = '0;
        wb_d            = ~wb_q;
      end else begin
        bank_st_d[wb_q] = B_FILLING;
        wcnt_d          = wcnt_q + LOG2N'(1);
      end
    end

    if (rd_fire) begin
      out_valid_d = 1'b1;
      out_a_d     = bank_mem[{rb_q, top_idx}];
      out_b_d     = bank_mem[{rb_q, bot_idx}];
      out_tw_d    = tw_idx;
      if (m_q == TWW'(NP - 1)) begin
        out_last_d      = 1'b1;
        bank_st_d[rb_q] = B_EMPTY;
        m_d             = '0;
        rb_d            = ~rb_q;
      end else begin
        bank_st_d[rb_q] = B_DRAINING;
        m_d             = m_q + TWW'(1);
      end
    end

    in_ready_d = (bank_st_d[wb_d] == B_EMPTY) || (bank_st_d[wb_d] == B_FILLING);
  end

  // State and output registers.
  always_ff @(posedge clock_c) begin
    if (reset) begin
      bank_st_q[0] <= B_EMPTY;
      bank_st_q[1] <= B_EMPTY;
      wb_q         <= 1'b0;
      rb_q         <= 1'b0;
      wcnt_q       <= '0;
      m_q          <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_tw_q     <= '0;
    end else begin
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
      wb_q         <= wb_d;
      rb_q         <= rb_d;
      wcnt_q       <= wcnt_d;
      m_q          <= m_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      out_tw_q     <= out_tw_d;
    end
  end

  // Sample storage; contents are never cleared.
  always_ff @(posedge clock_c) begin
    if (wr_fire) begin
      bank_mem[{wb_q, wr_addr}] <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_tw    = out_tw_q;

endmodule

// File: tb/tb_fft_stage_pair_buffer.sv
// Bench for fft_stage_pair_buffer: three stage configurations share one stimulus
// stream and are checked against a frame-level pair model every cycle.
module tb_fft_stage_pair_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        out_en;

  logic [15:0] oa [3];
  logic [15:0] ob [3];
  logic [3:0]  otw [3];
  logic        ov [3];
  logic        ol [3];
  logic        ir [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fft_stage_pair_buffer #(.LOG2N(5), .STAGE(0), .BITREV_IN(1'b1)) u_s0 (
    .clock_c(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
    .out_en(out_en), .out_a(oa[0]), .out_b(ob[0]), .out_tw(otw[0]), .out_valid(ov[0]), .out_last(ol[0]));

  fft_stage_pair_buffer #(.LOG2N(5), .STAGE(4), .BITREV_IN(1'b0)) u_s4 (
    .clock_c(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
    .out_en(out_en), .out_a(oa[1]), .out_b(ob[1]), .out_tw(otw[1]), .out_valid(ov[1]), .out_last(ol[1]));

  fft_stage_pair_buffer #(.LOG2N(5), .STAGE(1), .BITREV_IN(1'b0)) u_s1 (
    .clock_c(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[2]),
    .out_en(out_en), .out_a(oa[2]), .out_b(ob[2]), .out_tw(otw[2]), .out_valid(ov[2]), .out_last(ol[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  function automatic int cfg_stage(input int d);
    case (d)
      0:       return 0;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int rev5(input int k);
    int r = 0;
    for (int i = 0; i < 5; i++) if (((k >> i) & 1) == 1) r = r | (1 << (4 - i));
    return r;
  endfunction

  // Model state: partial frame, expected pair stream {a,b,tw,last}, observed pairs.
  logic [15:0] part_q [3][$];
  logic [36:0] exp_q  [3][$];
  logic [36:0] obs_q  [3][$];
  int          avail [3];
  int          pend  [3];
  bit          exp_valid [3];
  bit          exp_ready [3];
  logic [15:0] hold_a [3];
  logic [15:0] hold_b [3];
  logic [3:0]  hold_tw [3];
  bit          started = 1'b0;
  bit          iss;
  logic [36:0] e;

  // Turn a completed frame into its 16 butterfly pairs.
  task automatic build_pairs(input int d);
    logic [15:0] x [32];
    int h, j, top, tw;
    for (int k = 0; k < 32; k++) x[(d == 0) ? rev5(k) : k] = part_q[d][k];
    h = 1 << cfg_stage(d);
    for (int m = 0; m < 16; m++) begin
      j   = m % h;
      top = (m / h) * 2 * h + j;
      tw  = j * (16 / h);
      exp_q[d].push_back({x[top], x[top + h], 4'(tw), (m == 15)});
    end
  endtask

  // Model update at each active edge.
  always @(posedge clk) begin
    started = 1'b1;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        part_q[d].delete();
        exp_q[d].delete();
        obs_q[d].delete();
        avail[d] = 0;
        pend[d] = 0;
        exp_valid[d] = 1'b0;
        exp_ready[d] = 1'b1;
        hold_a[d] = '0;
        hold_b[d] = '0;
        hold_tw[d] = '0;
      end else begin
        iss = out_en && (avail[d] > 0);
        if (iss) begin
          avail[d]--;
          if (avail[d] % 16 == 0) pend[d]--;
        end
        if (in_valid && exp_ready[d]) begin
          part_q[d].push_back(in_data);
          if (part_q[d].size() == 32) begin
            build_pairs(d);
            part_q[d].delete();
            avail[d] += 16;
            pend[d]++;
          end
        end
        exp_ready[d] = (pend[d] < 2);
        exp_valid[d] = iss;
      end
    end
  end

  // Compare DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("out_valid[%0d]", d), 64'(ov[d]), 64'(exp_valid[d]));
        if (exp_valid[d] && exp_q[d].size() > 0) begin
          e = exp_q[d].pop_front();
          hold_a[d]  = e[36:21];
          hold_b[d]  = e[20:5];
          hold_tw[d] = e[4:1];
          chk($sformatf("out_a[%0d]", d), 64'(oa[d]), 64'(e[36:21]));
          chk($sformatf("out_b[%0d]", d), 64'(ob[d]), 64'(e[20:5]));
          chk($sformatf("out_tw[%0d]", d), 64'(otw[d]), 64'(e[4:1]));
          chk($sformatf("out_last[%0d]", d), 64'(ol[d]), 64'(e[0]));
        end else if (!ov[d]) begin
          chk($sformatf("hold_a[%0d]", d), 64'(oa[d]), 64'(hold_a[d]));
          chk($sformatf("hold_b[%0d]", d), 64'(ob[d]), 64'(hold_b[d]));
          chk($sformatf("hold_tw[%0d]", d), 64'(otw[d]), 64'(hold_tw[d]));
        end
        if (ov[d]) obs_q[d].push_back({oa[d], ob[d], otw[d], ol[d]});
        chk($sformatf("in_ready[%0d]", d), 64'(ir[d]), 64'(exp_ready[d]));
      end
    end
  end

  task automatic chk_pair(input string nm, input int d, input int idx,
                          input logic [15:0] a, input logic [15:0] b, input logic [3:0] tw);
    logic [36:0] p;
    if (idx < obs_q[d].size()) begin
      p = obs_q[d][idx];
      chk({nm, "_a"}, 64'(p[36:21]), 64'(a));
      chk({nm, "_b"}, 64'(p[20:5]), 64'(b));
      chk({nm, "_tw"}, 64'(p[4:1]), 64'(tw));
    end else begin
      chk({nm, "_present"}, 64'(obs_q[d].size()), 64'(idx + 1));
    end
  endtask

  task automatic chk_last(input string nm, input int d, input int idx, input logic l);
    logic [36:0] p;
    if (idx < obs_q[d].size()) begin
      p = obs_q[d][idx];
      chk(nm, 64'(p[0]), 64'(l));
    end else begin
      chk({nm, "_present"}, 64'(obs_q[d].size()), 64'(idx + 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(ov[0]), 64'd0);
    chk("reset_in_ready", 64'(ir[0]), 64'd1);
    chk("reset_out_a", 64'(oa[0]), 64'd0);
    chk("reset_out_b", 64'(ob[0]), 64'd0);
    chk("reset_out_tw", 64'(otw[0]), 64'd0);
    chk("reset_out_last", 64'(ol[0]), 64'd0);
    rst = 1'b0;

    // Streaming frame with continuous drain.
    out_en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1; in_data = {8'(k), 8'h00};
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t1_latency_1", 64'(ov[0]), 64'd0);
    @(negedge clk);
    chk("t1_latency_2", 64'(ov[0]), 64'd1);
    repeat (20) @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("t1_npairs[%0d]", d), 64'(obs_q[d].size()), 64'd16);
    chk_pair("t1_s0_m0", 0, 0, 16'h0000, 16'h1000, 4'd0);
    chk_pair("t1_s0_m1", 0, 1, 16'h0800, 16'h1800, 4'd0);
    chk_last("t1_s0_last14", 0, 14, 1'b0);
    chk_last("t1_s0_last15", 0, 15, 1'b1);
    chk_pair("t1_s4_m3", 1, 3, 16'h0300, 16'h1300, 4'd3);
    chk_pair("t1_s4_m15", 1, 15, 16'h0f00, 16'h1f00, 4'd15);
    chk_pair("t1_s1_m1", 2, 1, 16'h0100, 16'h0300, 4'd8);
    chk_pair("t1_s1_m2", 2, 2, 16'h0400, 16'h0600, 4'd0);
    chk_pair("t1_s1_m3", 2, 3, 16'h0500, 16'h0700, 4'd8);

    // Backpressure: three frames offered with drain disabled.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    out_en = 1'b0; acc = 0;
    for (int i = 0; i < 96; i++) begin
      in_valid = 1'b1; in_data = {8'(i), 8'h80 ^ 8'(i)};
      if (ir[0]) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_accepts", 64'(acc), 64'd64);
    chk("bp_in_ready_low", 64'(ir[0]), 64'd0);
    out_en = 1'b1;
    repeat (15) @(negedge clk);
    chk("bp_ready_before_last", 64'(ir[0]), 64'd0);
    @(negedge clk);
    chk("bp_ready_after_last", 64'(ir[0]), 64'd1);
    for (int i = 0; i < 32; i++) begin
      out_en = (i % 2 == 0);
      @(negedge clk);
    end
    out_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_npairs", 64'(obs_q[0].size()), 64'd32);
    chk_pair("bp_f1_m0", 0, 0, 16'h0080, 16'h1090, 4'd0);
    chk_pair("bp_f1_m1", 0, 1, 16'h0888, 16'h1898, 4'd0);
    chk_pair("bp_f2_m0", 0, 16, 16'h20a0, 16'h30b0, 4'd0);

    // Reset with one partial frame stored and one frame mid-drain.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    out_en = 1'b0;
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1; in_data = {8'(k), 8'ha5};
      @(negedge clk);
    end
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_data = {8'(k), 8'h3c};
      @(negedge clk);
    end
    in_valid = 1'b0; out_en = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1; out_en = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 64'(ov[0]), 64'd0);
    chk("rst_mid_in_ready", 64'(ir[0]), 64'd1);
    rst = 1'b0;
    out_en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1; in_data = {8'(k), 8'(k) ^ 8'h5a};
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (25) @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("rst_npairs[%0d]", d), 64'(obs_q[d].size()), 64'd16);
    chk_pair("rst_s0_m0", 0, 0, 16'h005a, 16'h104a, 4'd0);
    chk_pair("rst_s4_m5", 1, 5, 16'h055f, 16'h154f, 4'd5);
    for (int d = 0; d < 3; d++) chk($sformatf("end_pending[%0d]", d), 64'(exp_q[d].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft_stage_pair_buffer.md
Name: fft_stage_pair_buffer

Overview:
- Ping-pong reorder buffer that sits directly upstream of the radix-2 DIT butterfly stage.
- Collects a frame of N complex samples arriving serially, one per cycle. Each sample is 16 bits: {re[15:8], im[7:0]}, 8-bit two's complement.
- Replays the frame as N/2 butterfly operand pairs (top, bottom) with the matching twiddle index for the configured stage.
- Its outputs feed the butterfly's A/B/twiddle-select inputs. The butterfly's clock-enable drives out_en.

Parameters:
- LOG2N, 5, log2 of frame length N (N=32); twiddle index width is LOG2N-1.
- STAGE, 0, DIT stage number s, 0..LOG2N-1; span h = 2^s.
- BITREV_IN, 1, 1 = write address is the bit-reversed input count (first stage); 0 = natural order.

Ports:
- clock_c  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- in_data  in  16  complex input sample {re,im}.
- in_valid  in  1  in_data present this cycle.
- in_ready  out  1  buffer can accept a sample this cycle.
- out_en  in  1  downstream enable; a pair is read only when high.
- out_a  out  16  top operand (x[top]).
- out_b  out  16  bottom operand (x[top+h]).
- out_tw  out  LOG2N-1  twiddle index for this pair.
- out_valid  out  1  out_a/out_b/out_tw valid this cycle.
- out_last  out  1  qualifies the final pair (m = N/2-1) of a frame.

Behaviour:
- Two banks, each N x 16 bits. Each bank has a state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - A sample is accepted when in_valid & in_ready.
  - Write address = bitrev(wcnt) if BITREV_IN, else wcnt. wcnt runs 0..N-1.
  - When wcnt = N-1 is accepted, the bank goes FULL, wcnt returns to 0, and the write bank toggles.
  - in_ready = 1 while the write bank is EMPTY or FILLING; 0 while both banks are FULL or DRAINING.
- Read side:
  - A read issues in a cycle when out_en=1 and the read bank is FULL or DRAINING.
  - Pair index m runs 0..N/2-1, with j = m & (h-1) and g = m >> s.
  - top = g*2h + j; bottom = top + h.
  - tw = j << (LOG2N-1-s), truncated to LOG2N-1 bits.
  - Latency is 1 cycle: out_a, out_b, out_tw, out_valid and out_last are registered in the cycle after the issue.
  - out_valid = 1 only for cycles following an issue. When no read issues, out_valid = 0 and the data outputs hold their last value.
  - After pair m = N/2-1 issues, the bank goes EMPTY, m returns to 0, and the read bank toggles.
  - A drain never stalls internally. Only out_en gates it.
- Simultaneous events:
  - Final write into bank X and final read of bank Y in the same cycle: both transitions happen. Next cycle X is FULL and Y is EMPTY.
  - A bank going FULL may start draining on the very next cycle. A read is never issued in the same cycle as the last write to that bank.
  - Write and read never target the same bank in one cycle.
- Reset:
  - Values: in_ready=1 (it follows from both banks EMPTY), out_valid=0, out_last=0, out_a=0, out_b=0, out_tw=0. Both banks EMPTY, wcnt=0, m=0, write bank and read bank = bank 0.
  - Reset mid-frame discards all partial and full frames.
  - Memory contents need no clearing.
- Arithmetic: data passes through unmodified. No scaling or sign handling.
- Steady-state throughput: N cycles per frame on the fill side, N/2 out_en cycles on the drain side.

Test Plan:
- Reset, LOG2N=5, STAGE=0, BITREV_IN=1. Stream in_data = {k,8'h00} for k=0..31 with in_valid=1, out_en=1.
  - in_ready stays 1 throughout.
  - First out_valid comes 2 cycles after the 32nd accept.
  - Pair m=0: out_a=16'h0000, out_b=16'h1000. Pair m=1: out_a=16'h0800, out_b=16'h1800.
  - out_tw=0 for all 16 pairs; out_last high only on the 16th pair.
- STAGE=4, BITREV_IN=0, same stream.
  - Pair m: out_a={m,8'h00}, out_b={m+16,8'h00}, out_tw=m, for m=0..15.
- STAGE=1, BITREV_IN=0: pairs (0,2),(1,3),(4,6),(5,7)... with out_tw sequence 0,8,0,8,...
- Backpressure: out_en=0 while three frames are offered.
  - After 64 accepts, in_ready=0 and the third frame's samples are not accepted.
  - Raising out_en drains frame 1 in order.
  - in_ready returns to 1 the cycle after frame 1's last pair issues.
- out_en toggled 1,0,1,0 during a drain.
  - out_valid follows the pattern one cycle delayed.
  - Outputs hold their value during gaps; pair order is unchanged and no pair is skipped.
- Assert reset after 20 samples of a frame plus one full frame mid-drain.
  - Next cycle: out_valid=0, in_ready=1.
  - A fresh 32-sample frame then produces exactly 16 correct pairs with no stale data.
